// File: rtl/ctrl_pipe_pkg.sv
// Shared definitions for the control-bundle pipeline.
// Bundle bit positions, bubble constant and forwarding select codes.
package ctrl_pipe_pkg;

    localparam int CTRL_REGWRITE = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_MEMREAD  = 5;
    localparam int CTRL_MEMWRITE = 4;
    localparam int CTRL_ALUOP_HI = 3;
    localparam int CTRL_ALUOP_LO = 2;
    localparam int CTRL_ALUSRC   = 1;
    localparam int CTRL_BRANCH   = 0;

    localparam logic [7:0] CTRL_BUBBLE = 8'b0;

    typedef enum logic [1:0] {
        FWD_REG = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_e;

endpackage

// File: rtl/ctrl_pipe_hazard_fwd.sv
// Combinational load-use detection and EX operand forwarding selects.
// Ports: EX/MEM/WB control+rd, ID and EX source indices -> hazard_o, fwd_a_o, fwd_b_o.
module hazard_fwd_unit
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5
) (
    input  logic              ex_mem_read_i,
    input  logic [REG_AW-1:0] ex_rd_i,
    input  logic [REG_AW-1:0] ex_rs1_i,
    input  logic [REG_AW-1:0] ex_rs2_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic              mem_reg_write_i,
    input  logic [REG_AW-1:0] mem_rd_i,
    input  logic              wb_reg_write_i,
    input  logic [REG_AW-1:0] wb_rd_i,
    output logic              hazard_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o
);

    // EX/MEM has the newer value, so it is tested first; x0 never forwards.
    function automatic fwd_e fwd_sel(input logic [REG_AW-1:0] rs);
        fwd_e sel;
        sel = FWD_REG;
        if (mem_reg_write_i && mem_rd_i != '0 && mem_rd_i == rs)
            sel = FWD_MEM;
        else if (wb_reg_write_i && wb_rd_i != '0 && wb_rd_i == rs)
            sel = FWD_WB;
        return sel;
    endfunction

    logic w_rd_hit;

    assign w_rd_hit = (ex_rd_i == id_rs1_i) || (ex_rd_i == id_rs2_i);
    assign hazard_o = ex_mem_read_i && (ex_rd_i != '0) && w_rd_hit;
    assign fwd_a_o  = fwd_sel(ex_rs1_i);
    assign fwd_b_o  = fwd_sel(ex_rs2_i);

endmodule

// File: rtl/ctrl_pipe.sv
// ID/EX, EX/MEM, MEM/WB control stage registers with load-use stall and forwarding.
// Ports: clk_i, rst_i, ctrl_i, id_rs*/rd_i, flush_i -> noop/stall, per-stage fields, fwd selects, stall_cnt_o.
module ctrl_pipe
    import ctrl_pipe_pkg::*;
#(
    parameter int REG_AW = 5,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [CTRL_W-1:0] ctrl_i,
    input  logic [REG_AW-1:0] id_rs1_i,
    input  logic [REG_AW-1:0] id_rs2_i,
    input  logic [REG_AW-1:0] id_rd_i,
    input  logic              flush_i,
    output logic              noop_o,
    output logic              stall_o,
    output logic [1:0]        ex_alu_op_o,
    output logic              ex_alu_src_o,
    output logic [1:0]        fwd_a_o,
    output logic [1:0]        fwd_b_o,
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic              wb_reg_write_o,
    output logic              wb_mem_to_reg_o,
    output logic [REG_AW-1:0] wb_rd_o,
    output logic [CNT_W-1:0]  stall_cnt_o
);

    logic [CTRL_W-1:0] r_ex_ctrl;
    logic [REG_AW-1:0] r_ex_rs1;
    logic [REG_AW-1:0] r_ex_rs2;
    logic [REG_AW-1:0] r_ex_rd;
    logic [3:0]        r_mem_ctrl;
    logic [REG_AW-1:0] r_mem_rd;
    logic [1:0]        r_wb_ctrl;
    logic [REG_AW-1:0] r_wb_rd;
    logic [CNT_W-1:0]  r_stall_cnt;

    logic w_hazard_raw;
    logic w_hazard;
    logic w_bubble;

    hazard_fwd_unit #(
        .REG_AW(REG_AW)
    ) u_hfu (
        .ex_mem_read_i  (r_ex_ctrl[CTRL_MEMREAD]),
        .ex_rd_i        (r_ex_rd),
        .ex_rs1_i       (r_ex_rs1),
        .ex_rs2_i       (r_ex_rs2),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .mem_reg_write_i(r_mem_ctrl[3]),
        .mem_rd_i       (r_mem_rd),
        .wb_reg_write_i (r_wb_ctrl[1]),
        .wb_rd_i        (r_wb_rd),
        .hazard_o       (w_hazard_raw),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o)
    );

    // Stage state is about to be discarded, so no stall is requested in reset.
    assign w_hazard = w_hazard_raw && !rst_i;
    assign w_bubble = w_hazard || flush_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ex_ctrl  <= '0;
            r_ex_rs1   <= '0;
            r_ex_rs2   <= '0;
            r_ex_rd    <= '0;
            r_mem_ctrl <= '0;
            r_mem_rd   <= '0;
            r_wb_ctrl  <= '0;
            r_wb_rd    <= '0;
        end else begin
            if (w_bubble) begin
                r_ex_ctrl <= CTRL_W'(CTRL_BUBBLE);
                r_ex_rs1  <= '0;
                r_ex_rs2  <= '0;
                r_ex_rd   <= '0;
            end else begin
                r_ex_ctrl <= ctrl_i;
                r_ex_rs1  <= id_rs1_i;
                r_ex_rs2  <= id_rs2_i;
                r_ex_rd   <= id_rd_i;
            end
            r_mem_ctrl <= r_ex_ctrl[CTRL_REGWRITE:CTRL_MEMWRITE];
            r_mem_rd   <= r_ex_rd;
            r_wb_ctrl  <= r_mem_ctrl[3:2];
            r_wb_rd    <= r_mem_rd;
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i)
            r_stall_cnt <= '0;
        else if (w_hazard && r_stall_cnt != '1)
            r_stall_cnt <= r_stall_cnt + CNT_W'(1);
    end

    assign noop_o          = w_hazard;
    assign stall_o         = w_hazard;
    assign ex_alu_op_o     = r_ex_ctrl[CTRL_ALUOP_HI:CTRL_ALUOP_LO];
    assign ex_alu_src_o    = r_ex_ctrl[CTRL_ALUSRC];
    assign mem_read_o      = r_mem_ctrl[1];
    assign mem_write_o     = r_mem_ctrl[0];
    assign wb_reg_write_o  = r_wb_ctrl[1];
    assign wb_mem_to_reg_o = r_wb_ctrl[0];
    assign wb_rd_o         = r_wb_rd;
    assign stall_cnt_o     = r_stall_cnt;

endmodule

// File: tb/tb_ctrl_pipe.sv
// Directed self-checking bench for ctrl_pipe (counter width 2 to reach saturation).
// Drives at posedge+1, checks 1 time unit later.
module tb_ctrl_pipe;

    localparam int REG_AW = 5;
    localparam int CTRL_W = 8;
    localparam int CNT_W  = 2;

    localparam logic [7:0] LW  = 8'hE2;
    localparam logic [7:0] ADD = 8'h88;
    localparam logic [7:0] SW  = 8'h12;

    logic              clk_i = 1'b0;
    logic              rst_i;
    logic [CTRL_W-1:0] ctrl_i;
    logic [REG_AW-1:0] id_rs1_i;
    logic [REG_AW-1:0] id_rs2_i;
    logic [REG_AW-1:0] id_rd_i;
    logic              flush_i;
    logic              noop_o;
    logic              stall_o;
    logic [1:0]        ex_alu_op_o;
    logic              ex_alu_src_o;
    logic [1:0]        fwd_a_o;
    logic [1:0]        fwd_b_o;
    logic              mem_read_o;
    logic              mem_write_o;
    logic              wb_reg_write_o;
    logic              wb_mem_to_reg_o;
    logic [REG_AW-1:0] wb_rd_o;
    logic [CNT_W-1:0]  stall_cnt_o;

    int n_chk  = 0;
    int n_pass = 0;

    ctrl_pipe #(
        .REG_AW(REG_AW),
        .CTRL_W(CTRL_W),
        .CNT_W (CNT_W)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .ctrl_i         (ctrl_i),
        .id_rs1_i       (id_rs1_i),
        .id_rs2_i       (id_rs2_i),
        .id_rd_i        (id_rd_i),
        .flush_i        (flush_i),
        .noop_o         (noop_o),
        .stall_o        (stall_o),
        .ex_alu_op_o    (ex_alu_op_o),
        .ex_alu_src_o   (ex_alu_src_o),
        .fwd_a_o        (fwd_a_o),
        .fwd_b_o        (fwd_b_o),
        .mem_read_o     (mem_read_o),
        .mem_write_o    (mem_write_o),
        .wb_reg_write_o (wb_reg_write_o),
        .wb_mem_to_reg_o(wb_mem_to_reg_o),
        .wb_rd_o        (wb_rd_o),
        .stall_cnt_o    (stall_cnt_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic [7:0] c, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rd,
                         input logic fl);
        ctrl_i   = c;
        id_rs1_i = rs1;
        id_rs2_i = rs2;
        id_rd_i  = rd;
        flush_i  = fl;
        #1;
    endtask

    initial begin
        // Reset with a busy bundle on the input.
        rst_i = 1'b1;
        drive(8'hFF, 5'd1, 5'd2, 5'd3, 1'b0);
        tick();
        tick();
        chk("rst_ex_aluop", 32'(ex_alu_op_o), 32'd0);
        chk("rst_ex_alusrc", 32'(ex_alu_src_o), 32'd0);
        chk("rst_mem_rd", 32'(mem_read_o), 32'd0);
        chk("rst_mem_wr", 32'(mem_write_o), 32'd0);
        chk("rst_wb_rw", 32'(wb_reg_write_o), 32'd0);
        chk("rst_wb_m2r", 32'(wb_mem_to_reg_o), 32'd0);
        chk("rst_wb_rd", 32'(wb_rd_o), 32'd0);
        chk("rst_fwd", 32'({fwd_a_o, fwd_b_o}), 32'd0);
        chk("rst_stall", 32'({stall_o, noop_o}), 32'd0);
        chk("rst_cnt", 32'(stall_cnt_o), 32'd0);
        rst_i = 1'b0;
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();

        // Load-use: lw x5 then add x8, x5, x6.
        drive(LW, 5'd0, 5'd0, 5'd5, 1'b0);
        chk("lu_pre_stall", 32'(stall_o), 32'd0);
        tick();
        drive(ADD, 5'd5, 5'd6, 5'd8, 1'b0);
        chk("lu_stall", 32'(stall_o), 32'd1);
        chk("lu_noop", 32'(noop_o), 32'd1);
        chk("lu_ex_lw_src", 32'(ex_alu_src_o), 32'd1);
        tick();
        chk("lu_bubble_op", 32'(ex_alu_op_o), 32'd0);
        chk("lu_bubble_src", 32'(ex_alu_src_o), 32'd0);
        chk("lu_one_cycle", 32'(stall_o), 32'd0);
        chk("lu_cnt", 32'(stall_cnt_o), 32'd1);
        chk("lu_mem_read", 32'(mem_read_o), 32'd1);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("lu_add_ex_op", 32'(ex_alu_op_o), 32'd2);
        chk("lu_fwd_a", 32'(fwd_a_o), 32'b01);
        chk("lu_fwd_b", 32'(fwd_b_o), 32'b00);
        chk("lu_wb_rw", 32'(wb_reg_write_o), 32'd1);
        chk("lu_wb_m2r", 32'(wb_mem_to_reg_o), 32'd1);
        chk("lu_wb_rd", 32'(wb_rd_o), 32'd5);
        tick();

        // Load into x0: no stall, no forwarding.
        drive(LW, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        drive(ADD, 5'd0, 5'd0, 5'd9, 1'b0);
        chk("x0_stall", 32'(stall_o), 32'd0);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("x0_fwd_a", 32'(fwd_a_o), 32'b00);
        chk("x0_fwd_b", 32'(fwd_b_o), 32'b00);
        tick();

        // Two writers of x3, reader on rs2: EX/MEM wins.
        drive(ADD, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        drive(ADD, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        drive(ADD, 5'd1, 5'd3, 5'd4, 1'b0);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("pri_fwd_b_mem", 32'(fwd_b_o), 32'b10);
        chk("pri_fwd_a", 32'(fwd_a_o), 32'b00);

        // Newer slot is a store: falls back to MEM/WB.
        drive(ADD, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        drive(SW, 5'd0, 5'd0, 5'd3, 1'b0);
        tick();
        drive(ADD, 5'd1, 5'd3, 5'd4, 1'b0);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("pri_fwd_b_wb", 32'(fwd_b_o), 32'b01);
        chk("pri_sw_memwr", 32'(mem_write_o), 32'd1);
        tick();

        // Flush alone squashes the ID slot.
        drive(8'h8C, 5'd0, 5'd0, 5'd3, 1'b1);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("fl_ex_op", 32'(ex_alu_op_o), 32'd0);
        tick();

        // Flush together with a load-use hazard.
        drive(LW, 5'd0, 5'd0, 5'd7, 1'b0);
        tick();
        drive(8'h9C, 5'd7, 5'd0, 5'd8, 1'b1);
        chk("flh_stall", 32'(stall_o), 32'd1);
        chk("flh_noop", 32'(noop_o), 32'd1);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        chk("flh_ex_op", 32'(ex_alu_op_o), 32'd0);
        chk("flh_cnt", 32'(stall_cnt_o), 32'd2);
        tick();
        chk("flh_mem_wr", 32'(mem_write_o), 32'd0);
        tick();
        chk("flh_wb_rw", 32'(wb_reg_write_o), 32'd0);

        // Saturation: ten edges of self-dependent loads give five hazards.
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        drive(LW, 5'd5, 5'd0, 5'd5, 1'b0);
        chk("sat_cnt_clr", 32'(stall_cnt_o), 32'd0);
        for (int i = 1; i <= 10; i++) begin
            tick();
            if (i == 6)
                chk("sat_cnt_3", 32'(stall_cnt_o), 32'd3);
        end
        chk("sat_cnt_hold", 32'(stall_cnt_o), 32'd3);

        // Reset while a writing load sits in MEM.
        drive(LW, 5'd0, 5'd0, 5'd6, 1'b0);
        tick();
        drive(8'h00, 5'd0, 5'd0, 5'd0, 1'b0);
        tick();
        chk("mid_mem_read", 32'(mem_read_o), 32'd1);
        rst_i = 1'b1;
        tick();
        rst_i = 1'b0;
        #1;
        chk("mid_wb_rw", 32'(wb_reg_write_o), 32'd0);
        chk("mid_wb_rd", 32'(wb_rd_o), 32'd0);
        chk("mid_mem_read0", 32'(mem_read_o), 32'd0);
        chk("mid_cnt", 32'(stall_cnt_o), 32'd0);
        tick();
        chk("mid_wb_after", 32'(wb_reg_write_o), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
